img_lut_bank_ctrl: RTL and testbench

IMG_LUT_BANK_CTRL -- requirements
Module: img_lut_bank_ctrl

---
 rtl/img_lut_pkg.sv | 18 +
 rtl/img_lut_bank_ctrl.sv | 135 +++++++++++++
 tb/tb_img_lut_bank_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/img_lut_pkg.sv
// Shared types and sizing for the double-banked image LUT controller.
package img_lut_pkg;

    localparam int PX_WIDTH_DEF = 10;
    localparam int NUM_BANKS    = 2;
    localparam int LUT_DEPTH    = 2 ** PX_WIDTH_DEF;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_PENDING = 2'd2
    } lut_state_t;

    function automatic int lut_depth(input int px_width);
        return 2 ** px_width;
    endfunction

endpackage

// File: rtl/img_lut_bank_ctrl.sv
// Ping-pong LUT bank controller: host writes the shadow bank, swaps land on SOF beats.
// Define IMG_LUT_INIT_RAMP_EN to identity-fill both banks after reset.
module img_lut_bank_ctrl
    import img_lut_pkg::*;
#(
    parameter int PX_WIDTH = PX_WIDTH_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                wr_valid_i,
    output logic                wr_ready_o,
    input  logic [PX_WIDTH-1:0] wr_addr_i,
    input  logic [PX_WIDTH-1:0] wr_data_i,
    input  logic                swap_req_i,
    input  logic                sof_valid_i,
    input  logic                sof_ready_i,
    input  logic                sof_user_i,
    output logic                ram_we_o,
    output logic [PX_WIDTH:0]   ram_addr_o,
    output logic [PX_WIDTH-1:0] ram_wdata_o,
    output logic                bank_sel_o,
    output logic                swap_pending_o,
    output logic                swap_done_o,
    output logic [15:0]         swap_cnt_o
);

    localparam int AW = PX_WIDTH + 1;

    lut_state_t          state_q, state_d;
    logic                active_q;
    logic                wr_pend_q;
    logic [AW-1:0]       wr_addr_q;
    logic [PX_WIDTH-1:0] wr_data_q;
    logic                swap_done_q;
    logic [15:0]         swap_cnt_q;
    logic                sof_beat, swap_fire, wr_fire;
    logic                fill_we, latched;
    logic [AW-1:0]       fill_addr;

`ifdef IMG_LUT_INIT_RAMP_EN
    localparam lut_state_t RST_STATE = ST_INIT;
    logic [AW-1:0] cnt_q;
    logic          latch_q, latch_d, fill_last;

    assign fill_we   = (state_q == ST_INIT);
    assign fill_addr = cnt_q;
    assign fill_last = fill_we && (cnt_q == AW'(NUM_BANKS * lut_depth(PX_WIDTH) - 1));
    assign latched   = latch_q;
`else
    localparam lut_state_t RST_STATE = ST_IDLE;

    assign fill_we   = 1'b0;
    assign fill_addr = '0;
    assign latched   = 1'b0;
`endif

    assign sof_beat = sof_valid_i && sof_ready_i && sof_user_i;
    assign wr_fire  = wr_valid_i && wr_ready_o;

    always_comb begin
        state_d   = state_q;
        swap_fire = 1'b0;
`ifdef IMG_LUT_INIT_RAMP_EN
        latch_d   = latch_q;
`endif
        unique case (state_q)
            // A SOF coincident with the request belongs to the old frame.
            ST_IDLE:    if (swap_req_i) state_d = ST_PENDING;
            ST_PENDING: begin
                if (sof_beat) begin
                    swap_fire = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
`ifdef IMG_LUT_INIT_RAMP_EN
            ST_INIT: begin
                if (swap_req_i) latch_d = 1'b1;
                if (fill_last) begin
                    state_d = latch_d ? ST_PENDING : ST_IDLE;
                    latch_d = 1'b0;
                end
            end
`endif
            default:    state_d = RST_STATE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= RST_STATE;
            active_q    <= 1'b0;
            wr_pend_q   <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            swap_done_q <= 1'b0;
            swap_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_pend_q   <= wr_fire;
            swap_done_q <= swap_fire;
            // Bank captured before any same-cycle swap takes effect.
            if (wr_fire) begin
                wr_addr_q <= {~active_q, wr_addr_i};
                wr_data_q <= wr_data_i;
            end
            if (swap_fire) begin
                active_q   <= ~active_q;
                swap_cnt_q <= swap_cnt_q + 16'd1;
            end
        end
    end

`ifdef IMG_LUT_INIT_RAMP_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            latch_q <= 1'b0;
        end else begin
            latch_q <= latch_d;
            if (fill_we) cnt_q <= cnt_q + AW'(1);
        end
    end
`endif

    // All control outputs are held quiet while reset is asserted.
    assign wr_ready_o     = !rst_i && (state_q != ST_INIT);
    assign ram_we_o       = !rst_i && (fill_we || wr_pend_q);
    assign ram_addr_o     = fill_we ? fill_addr : wr_addr_q;
    assign ram_wdata_o    = fill_we ? fill_addr[PX_WIDTH-1:0] : wr_data_q;
    assign bank_sel_o     = !rst_i && (swap_fire ? ~active_q : active_q);
    assign swap_pending_o = !rst_i && ((state_q == ST_PENDING) || latched);
    assign swap_done_o    = !rst_i && swap_done_q;
    assign swap_cnt_o     = swap_cnt_q;

endmodule

// File: tb/tb_img_lut_bank_ctrl.sv
// Directed bench for img_lut_bank_ctrl at PX_WIDTH=4, both IMG_LUT_INIT_RAMP_EN builds.
module tb_img_lut_bank_ctrl;

    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst, wr_valid, swap_req, sof_valid, sof_ready, sof_user;
    logic [PW-1:0] wr_addr, wr_data;
    logic          wr_ready, ram_we, bank_sel, swap_pending, swap_done;
    logic [PW:0]   ram_addr;
    logic [PW-1:0] ram_wdata;
    logic [15:0]   swap_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    img_lut_bank_ctrl #(.PX_WIDTH(PW)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .wr_valid_i     (wr_valid),
        .wr_ready_o     (wr_ready),
        .wr_addr_i      (wr_addr),
        .wr_data_i      (wr_data),
        .swap_req_i     (swap_req),
        .sof_valid_i    (sof_valid),
        .sof_ready_i    (sof_ready),
        .sof_user_i     (sof_user),
        .ram_we_o       (ram_we),
        .ram_addr_o     (ram_addr),
        .ram_wdata_o    (ram_wdata),
        .bank_sel_o     (bank_sel),
        .swap_pending_o (swap_pending),
        .swap_done_o    (swap_done),
        .swap_cnt_o     (swap_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and drop all pulse-style inputs.
    task automatic cyc();
        @(negedge clk);
        wr_valid  = 1'b0;
        swap_req  = 1'b0;
        sof_valid = 1'b0;
        sof_ready = 1'b0;
        sof_user  = 1'b0;
    endtask

    task automatic sof_all();
        sof_valid = 1'b1;
        sof_ready = 1'b1;
        sof_user  = 1'b1;
    endtask

    task automatic host_wr(input logic [PW-1:0] a, input logic [PW-1:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
    endtask

`ifdef IMG_LUT_INIT_RAMP_EN
    // Called on the first cycle after reset release; req_at < 0 means no swap request.
    task automatic fill_check(input int req_at);
        for (int i = 0; i < 32; i++) begin
            if (i > 0) cyc();
            if (i == req_at) swap_req = 1'b1;
            #1;
            chk("fill_we", 32'(ram_we), 32'd1);
            chk("fill_addr", 32'(ram_addr), 32'(i));
            chk("fill_data", 32'(ram_wdata), 32'(i % 16));
            chk("fill_rdy", 32'(wr_ready), 32'd0);
            chk("fill_pend", 32'(swap_pending), 32'((req_at >= 0) && (i > req_at)));
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        wr_addr = '0;
        wr_data = '0;
        repeat (3) cyc();
        #1;
        chk("rst_rdy", 32'(wr_ready), 32'd0);
        chk("rst_we", 32'(ram_we), 32'd0);
        chk("rst_bank", 32'(bank_sel), 32'd0);
        chk("rst_pend", 32'(swap_pending), 32'd0);
        chk("rst_done", 32'(swap_done), 32'd0);
        chk("rst_cnt", 32'(swap_cnt), 32'd0);

        cyc();
        rst = 1'b0;
`ifdef IMG_LUT_INIT_RAMP_EN
        fill_check(-1);
        cyc();
        #1;
        chk("post_fill_rdy", 32'(wr_ready), 32'd1);
        chk("post_fill_we", 32'(ram_we), 32'd0);
        chk("post_fill_pend", 32'(swap_pending), 32'd0);
`else
        #1;
        chk("idle_rdy", 32'(wr_ready), 32'd1);
        chk("idle_we0", 32'(ram_we), 32'd0);
        repeat (3) begin
            cyc();
            #1;
            chk("idle_we_quiet", 32'(ram_we), 32'd0);
        end
`endif

        // Host writes into shadow bank 1 while bank 0 is active.
        cyc(); host_wr(4'd3, 4'd9); #1;
        chk("wr_rdy", 32'(wr_ready), 32'd1);
        chk("wr_lat0", 32'(ram_we), 32'd0);
        cyc(); host_wr(4'hF, 4'h5); #1;
        chk("wr1_we", 32'(ram_we), 32'd1);
        chk("wr1_addr", 32'(ram_addr), 32'h13);
        chk("wr1_data", 32'(ram_wdata), 32'd9);
        cyc(); #1;
        chk("wr2_addr", 32'(ram_addr), 32'h1F);
        chk("wr2_data", 32'(ram_wdata), 32'd5);
        cyc(); #1;
        chk("wr_idle_we", 32'(ram_we), 32'd0);

        // Swap request, five non-SOF beats, then the SOF beat with a host write.
        cyc(); swap_req = 1'b1; #1;
        chk("req_bank", 32'(bank_sel), 32'd0);
        chk("req_pend", 32'(swap_pending), 32'd0);
        for (int k = 0; k < 5; k++) begin
            cyc();
            sof_valid = (k != 3);
            sof_ready = (k != 2);
            sof_user  = (k == 2) || (k == 3);
            #1;
            chk("pend_nosof", 32'(swap_pending), 32'd1);
            chk("bank_nosof", 32'(bank_sel), 32'd0);
        end
        cyc(); sof_all(); host_wr(4'd7, 4'd2); #1;
        chk("sof_bank", 32'(bank_sel), 32'd1);
        chk("sof_done", 32'(swap_done), 32'd0);
        cyc(); #1;
        chk("done_pulse", 32'(swap_done), 32'd1);
        chk("done_cnt", 32'(swap_cnt), 32'd1);
        chk("done_bank", 32'(bank_sel), 32'd1);
        chk("done_pend", 32'(swap_pending), 32'd0);
        chk("swapwr_addr", 32'(ram_addr), 32'h17);
        chk("swapwr_data", 32'(ram_wdata), 32'd2);
        cyc(); #1;
        chk("done_clr", 32'(swap_done), 32'd0);
        cyc(); host_wr(4'd3, 4'd9);
        cyc(); #1;
        chk("wr_b0_addr", 32'(ram_addr), 32'h03);

        // Request coincident with SOF, repeat request while pending: one swap only.
        cyc(); swap_req = 1'b1; sof_all(); #1;
        chk("coinc_bank", 32'(bank_sel), 32'd1);
        chk("coinc_pend", 32'(swap_pending), 32'd0);
        cyc(); swap_req = 1'b1; #1;
        chk("dbl_pend", 32'(swap_pending), 32'd1);
        chk("dbl_bank", 32'(bank_sel), 32'd1);
        cyc(); sof_all(); #1;
        chk("sof2_bank", 32'(bank_sel), 32'd0);
        cyc(); #1;
        chk("done2", 32'(swap_done), 32'd1);
        chk("cnt2", 32'(swap_cnt), 32'd2);
        chk("bank2", 32'(bank_sel), 32'd0);
        cyc(); sof_all(); #1;
        chk("nosecond_bank", 32'(bank_sel), 32'd0);
        cyc(); #1;
        chk("nosecond_cnt", 32'(swap_cnt), 32'd2);
        chk("nosecond_done", 32'(swap_done), 32'd0);

        // Back to active=1, go pending, then reset mid-pending.
        cyc(); swap_req = 1'b1;
        cyc(); sof_all();
        cyc(); #1;
        chk("cnt3", 32'(swap_cnt), 32'd3);
        chk("bank3", 32'(bank_sel), 32'd1);
        cyc(); swap_req = 1'b1;
        cyc(); #1;
        chk("pre_rst_pend", 32'(swap_pending), 32'd1);
        cyc(); rst = 1'b1; #1;
        chk("inrst_pend", 32'(swap_pending), 32'd0);
        chk("inrst_bank", 32'(bank_sel), 32'd0);
        chk("inrst_we", 32'(ram_we), 32'd0);
        chk("inrst_rdy", 32'(wr_ready), 32'd0);
        cyc(); rst = 1'b0; #1;
        chk("postrst_bank", 32'(bank_sel), 32'd0);
        chk("postrst_cnt", 32'(swap_cnt), 32'd0);
`ifdef IMG_LUT_INIT_RAMP_EN
        // Restarted fill with a swap request latched during INIT.
        fill_check(2);
        cyc(); #1;
        chk("latch_pend", 32'(swap_pending), 32'd1);
        chk("latch_rdy", 32'(wr_ready), 32'd1);
        chk("latch_bank", 32'(bank_sel), 32'd0);
        cyc(); sof_all(); #1;
        chk("latch_sof_bank", 32'(bank_sel), 32'd1);
        cyc(); #1;
        chk("latch_done", 32'(swap_done), 32'd1);
        chk("latch_cnt", 32'(swap_cnt), 32'd1);
`else
        chk("postrst_pend", 32'(swap_pending), 32'd0);
        chk("postrst_rdy", 32'(wr_ready), 32'd1);
        chk("postrst_we", 32'(ram_we), 32'd0);
        cyc(); #1;
        chk("postrst_we1", 32'(ram_we), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
